regfile_sb: RTL and testbench

Parametrised multi-read-port register file with an integrated write-pending scoreboard. It is the successor to the fixed 32x32, two-read-port file. It sits in the decode/writeback boundary of the five-stage pipeline. Issue logic reserves a destination register, and writeback later writes it and releases the reservation. Hazard logic reads per-port busy flags and decides whether to stall.

---
 rtl/regfile_sb.sv | 91 +++++++++
 tb/tb_regfile_sb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-pending scoreboard.
// Optional same-cycle write bypass: define REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int NUM_READ = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_READ*AW-1:0]    ReadRegister,
  output logic [NUM_READ*WIDTH-1:0] ReadData,
  output logic [NUM_READ-1:0]       ReadBusy,
  input  logic [AW-1:0]             WriteRegister,
  input  logic [WIDTH-1:0]          WriteData,
  input  logic                      RegWrite,
  input  logic [AW-1:0]             ReserveRegister,
  input  logic                      Reserve,
  output logic                      ReserveReady,
  output logic [AW:0]               BusyCount
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;

  logic wr_ok, rsv_ok, rsv_acc;
  logic same_reg, inc, dec;

  // Address is backed by real, writable state
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic busy_at(input logic [AW-1:0] a);
    return addr_ok(a) ? busy_q[a] : 1'b0;
  endfunction

  assign wr_ok    = RegWrite && addr_ok(WriteRegister);
  assign rsv_ok   = addr_ok(ReserveRegister);
  assign same_reg = RegWrite && (WriteRegister == ReserveRegister);

  assign ReserveReady = !rsv_ok
                     || !busy_at(ReserveRegister)
                     || same_reg;

  assign rsv_acc = Reserve && ReserveReady && rsv_ok;

  // Next busy vector and population count
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)   busy_d[WriteRegister]   = 1'b0;
    if (rsv_acc) busy_d[ReserveRegister] = 1'b1;
    inc   = rsv_acc && !busy_at(ReserveRegister);
    dec   = wr_ok && busy_at(WriteRegister)
         && !(rsv_acc && (WriteRegister == ReserveRegister));
    cnt_d = cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
  end

  // State update with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) mem_q[WriteRegister] <= WriteData;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign BusyCount = cnt_q;

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          byp;
    assign ra = ReadRegister[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign byp = rst_n && wr_ok && (WriteRegister == ra);
`else
    assign byp = 1'b0;
`endif
    assign ReadData[i*WIDTH +: WIDTH] =
      byp          ? WriteData :
      addr_ok(ra)  ? mem_q[ra] : '0;
    assign ReadBusy[i] = !byp && busy_at(ra);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb, default parameters.
// Bypass expectations follow REGFILE_BYPASS_EN.
module tb_regfile_sb;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2*AW-1:0] rreg;
  logic [2*W-1:0]  rdata;
  logic [1:0]      rbusy;
  logic [AW-1:0]   wreg;
  logic [W-1:0]    wdata;
  logic            we;
  logic [AW-1:0]   sreg;
  logic            rsv;
  logic            rdy;
  logic [AW:0]     bcnt;

  int npass = 0;
  int ntot  = 0;

  regfile_sb dut (
    .clk(clk),
    .rst_n(rst_n),
    .ReadRegister(rreg),
    .ReadData(rdata),
    .ReadBusy(rbusy),
    .WriteRegister(wreg),
    .WriteData(wdata),
    .RegWrite(we),
    .ReserveRegister(sreg),
    .Reserve(rsv),
    .ReserveReady(rdy),
    .BusyCount(bcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we  = 1'b0;
    rsv = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a0,
                    input logic [AW-1:0] a1);
    rreg = {a1, a0};
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a,
                    input logic [W-1:0] d);
    we = 1'b1; wreg = a; wdata = d;
  endtask

  task automatic res(input logic [AW-1:0] a);
    rsv = 1'b1; sreg = a;
  endtask

  initial begin
    rst_n = 1'b0;
    rreg = '0; wreg = '0; wdata = '0;
    sreg = '0; we = 1'b0; rsv = 1'b0;
    // traffic during reset must be dropped
    wr(5'd1, 32'h11);
    res(5'd2);
    tick();
    rst_n = 1'b1;
    idle();
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      chk("rst_rd", {32'h0, rdata}, 64'h0);
      chk("rst_bz", {62'h0, rbusy}, 64'h0);
    end
    chk("rst_cnt", {58'h0, bcnt}, 64'h0);
    chk("rst_rdy", {63'h0, rdy}, 64'h1);

    // plain write then read on both ports
    wr(5'd5, 32'hDEADBEEF);
    tick(); idle();
    rd(5'd5, 5'd5);
    chk("wr_r5", {32'h0, rdata}, 64'hDEADBEEF_DEADBEEF);

    // zero register ignores writes and reservations
    wr(5'd0, 32'h1234);
    res(5'd0);
    rd(5'd0, 5'd5);
    chk("r0_rdy", {63'h0, rdy}, 64'h1);
    tick(); idle();
    rd(5'd0, 5'd0);
    chk("r0_rd", {32'h0, rdata}, 64'h0);
    chk("r0_bz", {62'h0, rbusy}, 64'h0);
    chk("r0_cnt", {58'h0, bcnt}, 64'h0);

    // reserve, duplicate reserve, release
    res(5'd7);
    rd(5'd7, 5'd7);
    chk("r7_rdy1", {63'h0, rdy}, 64'h1);
    tick(); idle();
    rd(5'd7, 5'd7);
    chk("r7_bz", {62'h0, rbusy}, 64'h3);
    chk("r7_cnt1", {58'h0, bcnt}, 64'h1);
    res(5'd7);
    #1;
    chk("r7_rdy0", {63'h0, rdy}, 64'h0);
    tick(); idle();
    chk("r7_cnt2", {58'h0, bcnt}, 64'h1);
    wr(5'd7, 32'h55);
    tick(); idle();
    rd(5'd7, 5'd7);
    chk("r7_clr", {62'h0, rbusy}, 64'h0);
    chk("r7_cnt0", {58'h0, bcnt}, 64'h0);
    chk("r7_data", {32'h0, rdata}, 64'h00000055_00000055);

    // write and re-reserve the same busy register
    res(5'd9);
    tick(); idle();
    chk("r9_cnt1", {58'h0, bcnt}, 64'h1);
    wr(5'd9, 32'hAA);
    res(5'd9);
    #1;
    chk("r9_rdy", {63'h0, rdy}, 64'h1);
    tick(); idle();
    rd(5'd9, 5'd9);
    chk("r9_data", {32'h0, rdata}, 64'h000000AA_000000AA);
    chk("r9_bz", {62'h0, rbusy}, 64'h3);
    chk("r9_cnt", {58'h0, bcnt}, 64'h1);
    // release r9 while reserving r10
    wr(5'd9, 32'hAA);
    res(5'd10);
    tick(); idle();
    chk("r10_cnt", {58'h0, bcnt}, 64'h1);
    wr(5'd10, 32'h0);
    tick(); idle();
    chk("r10_cnt0", {58'h0, bcnt}, 64'h0);

    // write to a busy register while reading it
    res(5'd3);
    tick(); idle();
    chk("r3_cnt", {58'h0, bcnt}, 64'h1);
    wr(5'd3, 32'hCAFE);
    rd(5'd3, 5'd3);
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd", {32'h0, rdata}, 64'h0000CAFE_0000CAFE);
    chk("byp_bz", {62'h0, rbusy}, 64'h0);
`else
    chk("byp_rd", {32'h0, rdata}, 64'h0);
    chk("byp_bz", {62'h0, rbusy}, 64'h3);
`endif
    tick(); idle();
    rd(5'd3, 5'd3);
    chk("r3_rd", {32'h0, rdata}, 64'h0000CAFE_0000CAFE);
    chk("r3_bz", {62'h0, rbusy}, 64'h0);
    chk("r3_cnt0", {58'h0, bcnt}, 64'h0);

    // reset in the middle of pending work
    res(5'd4);
    tick();
    res(5'd6);
    tick(); idle();
    chk("mid_cnt2", {58'h0, bcnt}, 64'h2);
    rst_n = 1'b0;
    wr(5'd4, 32'hFF);
    res(5'd8);
    rd(5'd4, 5'd4);
`ifdef REGFILE_BYPASS_EN
    chk("mid_nobyp", {32'h0, rdata}, 64'h0);
`endif
    tick(); idle();
    rst_n = 1'b1;
    rd(5'd4, 5'd6);
    chk("mid_rd", {32'h0, rdata}, 64'h0);
    chk("mid_bz", {62'h0, rbusy}, 64'h0);
    chk("mid_cnt", {58'h0, bcnt}, 64'h0);
    rd(5'd5, 5'd8);
    chk("mid_r5", {32'h0, rdata}, 64'h0);
    chk("mid_bz8", {62'h0, rbusy}, 64'h0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
